// File: rtl/nz_pkg.sv
// rtl/nz_pkg.sv - shared widths, state encoding and beat record for nz_pair_sequencer
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 8
`endif

package nz_pkg;

  localparam int NZ_SIZE = `PREFIX_SUM_SIZE;
  localparam int NZ_W    = $clog2(NZ_SIZE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } nz_state_e;

  typedef struct packed {
    logic [NZ_W:0] pos;
    logic [NZ_W:0] idx_a;
    logic [NZ_W:0] idx_b;
    logic          last;
  } nz_beat_t;

endpackage

// File: rtl/lsb_priority_encoder.sv
// rtl/lsb_priority_encoder.sv - lowest-set-bit finder over a 1-based [SIZE:1] vector
module lsb_priority_encoder #(
  parameter int SIZE = 8,
  parameter int W    = $clog2(SIZE)
) (
  input  logic [SIZE:1] vec_i,
  output logic [W:0]    pos_o,
  output logic [SIZE:1] onehot_o,
  output logic          found_o
);

  // Scan from the top so the lowest set bit is the last writer.
  always_comb begin
    pos_o    = '0;
    onehot_o = '0;
    found_o  = 1'b0;
    for (int i = SIZE; i >= 1; i--) begin
      if (vec_i[i]) begin
        pos_o       = i[W:0];
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        found_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nz_pair_sequencer.sv
// rtl/nz_pair_sequencer.sv - walks common nonzero positions of two masks; NZ_PAIR_EMPTY_FLAG_EN adds out_empty_o
module nz_pair_sequencer
  import nz_pkg::*;
#(
  parameter int SIZE = NZ_SIZE,
  parameter int W    = NZ_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [SIZE:1]       mask_a_i,
  input  logic [SIZE:1]       mask_b_i,
  input  logic [SIZE:1][W:0]  psum_a_i,
  input  logic [SIZE:1][W:0]  psum_b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [W:0]          out_pos_o,
  output logic [W:0]          out_idx_a_o,
  output logic [W:0]          out_idx_b_o,
  output logic                out_last_o
`ifdef NZ_PAIR_EMPTY_FLAG_EN
  ,
  output logic                out_empty_o
`endif
);

  localparam logic [W:0]    IDX_ONE   = 1;
  localparam logic [SIZE:1] MATCH_ONE = 1;

  nz_state_e          r_state;
  logic [SIZE:1]      r_match;
  logic [SIZE:1][W:0] r_psum_a;
  logic [SIZE:1][W:0] r_psum_b;
`ifdef NZ_PAIR_EMPTY_FLAG_EN
  logic               r_empty;
`endif

  logic [W:0]    w_pos;
  logic [SIZE:1] w_onehot;
  logic          w_found;
  logic [W:0]    w_sel_a;
  logic [W:0]    w_sel_b;
  logic          w_run;
  logic          w_single;
  logic          w_accept;
  logic          w_handshake;
  logic [SIZE:1] w_in_match;
  nz_beat_t      w_beat;

  lsb_priority_encoder #(
    .SIZE (SIZE),
    .W    (W)
  ) u_enc (
    .vec_i    (r_match),
    .pos_o    (w_pos),
    .onehot_o (w_onehot),
    .found_o  (w_found)
  );

  // One-hot mux of the registered prefix sums at the selected position.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 1; i <= SIZE; i++) begin
      if (w_onehot[i]) begin
        w_sel_a = w_sel_a | r_psum_a[i];
        w_sel_b = w_sel_b | r_psum_b[i];
      end
    end
  end

  assign w_run      = (r_state == ST_RUN);
  assign w_single   = w_found && ((r_match & (r_match - MATCH_ONE)) == '0);
  assign w_in_match = mask_a_i & mask_b_i;

  always_comb begin
    w_beat.pos   = (w_run && w_found) ? w_pos             : '0;
    w_beat.idx_a = (w_run && w_found) ? w_sel_a - IDX_ONE : '0;
    w_beat.idx_b = (w_run && w_found) ? w_sel_b - IDX_ONE : '0;
`ifdef NZ_PAIR_EMPTY_FLAG_EN
    w_beat.last  = w_run && (r_empty || w_single);
`else
    w_beat.last  = w_run && w_single;
`endif
  end

  assign out_valid_o = w_run;
  assign out_pos_o   = w_beat.pos;
  assign out_idx_a_o = w_beat.idx_a;
  assign out_idx_b_o = w_beat.idx_b;
  assign out_last_o  = w_beat.last;
`ifdef NZ_PAIR_EMPTY_FLAG_EN
  assign out_empty_o = w_run && r_empty;
`endif

  // Accepting on the final beat keeps the pipe full with no idle bubble.
  assign in_ready_o  = !w_run || (w_beat.last && out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_handshake = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_match  <= '0;
      r_psum_a <= '0;
      r_psum_b <= '0;
`ifdef NZ_PAIR_EMPTY_FLAG_EN
      r_empty  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_match  <= w_in_match;
      r_psum_a <= psum_a_i;
      r_psum_b <= psum_b_i;
`ifdef NZ_PAIR_EMPTY_FLAG_EN
      r_state  <= ST_RUN;
      r_empty  <= (w_in_match == '0);
`else
      r_state  <= (w_in_match != '0) ? ST_RUN : ST_IDLE;
`endif
    end else if (w_handshake) begin
      r_match <= r_match & ~w_onehot;
      if (w_beat.last) begin
        r_state <= ST_IDLE;
`ifdef NZ_PAIR_EMPTY_FLAG_EN
        r_empty <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nz_pair_sequencer.sv
// tb/tb_nz_pair_sequencer.sv - self-checking bench for nz_pair_sequencer (SIZE=8)
module tb_nz_pair_sequencer;

  localparam int SIZE = 8;
  localparam int W    = 3;
`ifdef NZ_PAIR_EMPTY_FLAG_EN
  localparam int EMPTY_BEATS = 1;
`else
  localparam int EMPTY_BEATS = 0;
`endif

  typedef struct {
    logic [W:0] pos;
    logic [W:0] ia;
    logic [W:0] ib;
    logic       last;
    logic       empty;
  } beat_t;

  typedef struct {
    logic [SIZE:1] a;
    logic [SIZE:1] b;
    int            beats;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [SIZE:1]      mask_a;
  logic [SIZE:1]      mask_b;
  logic [SIZE:1][W:0] psum_a;
  logic [SIZE:1][W:0] psum_b;
  logic               out_valid;
  logic               out_ready;
  logic [W:0]         out_pos;
  logic [W:0]         out_ia;
  logic [W:0]         out_ib;
  logic               out_last;
  logic               out_empty;

  nz_pair_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mask_a_i    (mask_a),
    .mask_b_i    (mask_b),
    .psum_a_i    (psum_a),
    .psum_b_i    (psum_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_pos_o   (out_pos),
    .out_idx_a_o (out_ia),
    .out_idx_b_o (out_ib),
    .out_last_o  (out_last)
`ifdef NZ_PAIR_EMPTY_FLAG_EN
    ,
    .out_empty_o (out_empty)
`endif
  );

`ifndef NZ_PAIR_EMPTY_FLAG_EN
  assign out_empty = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  int    beat_cnt = 0;
  int    b2b_hits = 0;
  logic  prev_stall = 1'b0;
  logic  b2b_pend = 1'b0;
  logic  bp_en = 1'b0;
  logic [13:0] snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [SIZE:1][W:0] psum_of(input logic [SIZE:1] m);
    logic [W:0] acc;
    logic [SIZE:1][W:0] p;
    acc = '0;
    for (int i = 1; i <= SIZE; i++) begin
      acc  = acc + {{W{1'b0}}, m[i]};
      p[i] = acc;
    end
    return p;
  endfunction

  task automatic push_beat(input int pos, input int ia, input int ib, input logic last, input logic empty);
    beat_t e;
    e.pos = pos[W:0]; e.ia = ia[W:0]; e.ib = ib[W:0]; e.last = last; e.empty = empty;
    exp_q.push_back(e);
  endtask

  task automatic push_model(input logic [SIZE:1] a, input logic [SIZE:1] b);
    logic [SIZE:1]      m;
    logic [SIZE:1][W:0] pa;
    logic [SIZE:1][W:0] pb;
    int k;
    int n;
    m  = a & b;
    pa = psum_of(a);
    pb = psum_of(b);
    k  = $countones(m);
    n  = 0;
    if (k == 0) begin
      if (EMPTY_BEATS == 1) push_beat(0, 0, 0, 1'b1, 1'b1);
    end else begin
      for (int i = 1; i <= SIZE; i++) begin
        if (m[i]) begin
          n++;
          push_beat(i, int'(pa[i]) - 1, int'(pb[i]) - 1, n == k, 1'b0);
        end
      end
    end
  endtask

  task automatic drive_vec(input logic [SIZE:1] a, input logic [SIZE:1] b, input bit use_model);
    int  guard;
    bit  ok;
    guard = 0;
    ok    = 1'b0;
    @(posedge clk); #1;
    mask_a   = a;
    mask_b   = b;
    psum_a   = psum_of(a);
    psum_b   = psum_of(b);
    in_valid = 1'b1;
    while (!ok && guard < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else guard++;
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (use_model) push_model(a, b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check({name, "_drained"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
    check({name, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic push_walk();
    push_beat(3, 1, 0, 1'b0, 1'b0);
    push_beat(6, 3, 1, 1'b0, 1'b0);
    push_beat(8, 4, 3, 1'b1, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: scoreboard pop on every handshake, stability under stall, no-bubble follow-up.
  always @(negedge clk) begin
    logic [13:0] cur;
    beat_t e;
    cur = {out_pos, out_ia, out_ib, out_last, out_empty};
    if (!rst_n) begin
      prev_stall = 1'b0;
      b2b_pend   = 1'b0;
    end else begin
      if (b2b_pend) begin
        check("b2b_no_bubble", {31'd0, out_valid}, 32'd1);
        b2b_hits++;
      end
      b2b_pend = 1'b0;
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_fields_held", {18'd0, cur}, {18'd0, snap});
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat {pos,ia,ib,last,empty}", {18'd0, cur}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat {pos,ia,ib,last,empty}", {18'd0, cur}, {18'd0, e.pos, e.ia, e.ib, e.last, e.empty});
        end
        if (out_last) check("in_ready_on_last", {31'd0, in_ready}, 32'd1);
        b2b_pend = out_last && in_valid && in_ready;
      end
      prev_stall = out_valid && !out_ready;
      snap       = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{a: 8'hB6, b: 8'hE4, beats: 3};
    tbl[1] = '{a: 8'hFF, b: 8'hFF, beats: 8};
    tbl[2] = '{a: 8'h0F, b: 8'hF0, beats: EMPTY_BEATS};
    tbl[3] = '{a: 8'h01, b: 8'h01, beats: 1};
    tbl[4] = '{a: 8'h80, b: 8'h80, beats: 1};
    tbl[5] = '{a: 8'hAA, b: 8'hFF, beats: 4};
    tbl[6] = '{a: 8'h5A, b: 8'h3C, beats: 2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mask_a = '0; mask_b = '0; psum_a = '0; psum_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_empty", {31'd0, out_empty}, 32'd0);
    check("rst_fields {pos,ia,ib}", {20'd0, out_pos, out_ia, out_ib}, 32'd0);
    rst_n = 1'b1;

    // Basic walk with hand-derived expectations.
    beat_cnt = 0;
    push_walk();
    drive_vec(8'hB6, 8'hE4, 1'b0);
    wait_drain("walk");
    check("walk_beats", beat_cnt, 32'd3);

    // Backpressure on beat 2 for three cycles.
    beat_cnt = 0;
    push_walk();
    drive_vec(8'hB6, 8'hE4, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_drain("bp");
    check("bp_beats", beat_cnt, 32'd3);

    // Back-to-back: second vector accepted on the final beat of the first.
    beat_cnt = 0;
    b2b_hits = 0;
    push_walk();
    push_beat(1, 0, 0, 1'b1, 1'b0);
    drive_vec(8'hB6, 8'hE4, 1'b0);
    drive_vec(8'h01, 8'h01, 1'b0);
    wait_drain("b2b");
    check("b2b_beats", beat_cnt, 32'd4);
    check("b2b_seen", b2b_hits, 32'd1);

`ifndef NZ_PAIR_EMPTY_FLAG_EN
    drive_vec(8'h0F, 8'hF0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("empty_in_ready", {31'd0, in_ready}, 32'd1);
      check("empty_no_valid", {31'd0, out_valid}, 32'd0);
    end
`endif

    // Table vectors under random backpressure.
    bp_en = 1'b1;
    for (int t = 0; t < 7; t++) begin
      beat_cnt = 0;
      drive_vec(tbl[t].a, tbl[t].b, 1'b1);
      wait_drain($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_beats", t), beat_cnt, tbl[t].beats);
    end
    bp_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset in the middle of the basic walk after its first beat.
    beat_cnt = 0;
    push_walk();
    drive_vec(8'hB6, 8'hE4, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid_async", {31'd0, out_valid}, 32'd0);
    check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    check("rstmid_valid_held", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("rstmid_no_leftover", {31'd0, out_valid}, 32'd0);
    check("rstmid_beats", beat_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nz_pair_sequencer.md
# nz_pair_sequencer

Sequential consumer of the prefix-sum stage in the sparse datapath. It accepts one pair of sparsity masks (operand A, operand B) together with their inclusive prefix sums. It then walks the positions where both operands are nonzero, lowest position first, emitting one matched pair per cycle. Each pair carries the compressed-buffer indices for A and B, which feed the MAC operand fetch.

## Interface
- SIZE, default `PREFIX_SUM_SIZE: mask length; positions are numbered 1..SIZE.
- W, default $clog2(SIZE): MSB index of count/index fields (fields are W+1 bits).

Clock and reset: one clock; reset is asynchronous and active-low.

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  block can accept an input vector
- mask_a_i  in  [SIZE:1]  operand A nonzero mask
- mask_b_i  in  [SIZE:1]  operand B nonzero mask
- psum_a_i  in  [W:0] x [SIZE:1]  inclusive prefix sum of mask_a_i
- psum_b_i  in  [W:0] x [SIZE:1]  inclusive prefix sum of mask_b_i
- out_valid_o  out  1  pair beat valid
- out_ready_i  in  1  downstream accepts beat
- out_pos_o  out  [W:0]  matched position, 1..SIZE
- out_idx_a_o  out  [W:0]  compressed A index = psum_a[pos]-1
- out_idx_b_o  out  [W:0]  compressed B index = psum_b[pos]-1
- out_last_o  out  1  final beat of the current vector
- out_empty_o  out  1  present only with NZ_PAIR_EMPTY_FLAG_EN

## Operation
- States: IDLE, RUN.
- In IDLE, in_ready_o=1. On in_valid_i&in_ready_o the block registers match_q = mask_a_i & mask_b_i, psum_a_q and psum_b_q.
  - match≠0: go to RUN.
  - match=0: handled per Configuration.
- RUN:
  - out_valid_o=1.
  - out_pos_o is the lowest set bit of match_q.
  - Indices come from the registered prefix sums at out_pos_o, minus 1. All arithmetic is unsigned W+1 bits; psum≥1 at any matched position, so there is no underflow.
  - out_last_o=1 when exactly one bit remains in match_q.
- Beat handshake is out_valid_o&out_ready_i. On a handshake, clear the bit at out_pos_o. On a handshake with out_last_o=1, go to IDLE.
- Back-to-back: during RUN, in_ready_o = out_last_o & out_ready_i.
  - An input accepted in that cycle loads directly and stays in RUN (or takes the empty path). There is no idle bubble.
- While out_valid_o=1 and out_ready_i=0, all out_* fields are held stable.
- in_valid_i while in_ready_o=0 is ignored. The upstream holds its data.
- mask_* and psum_* are sampled only at the input handshake.

## Timing
- Reset values: state=IDLE, match_q=0, psum regs=0. Outputs: in_ready_o=1, out_valid_o=0, out_last_o=0, out_empty_o=0, and out_pos_o/out_idx_a_o/out_idx_b_o=0.
- Latency: input handshake at edge N gives the first beat valid in the cycle after N.
- Throughput: one pair per cycle with out_ready_i held high. A vector with k matches occupies k cycles.
- Reset mid-RUN: the vector is discarded, out_valid_o drops immediately (async), and the block resumes in IDLE.
- All outputs are decoded from registers only, except in_ready_o, which depends combinationally on out_ready_i.

## Configuration
- NZ_PAIR_EMPTY_FLAG_EN defined:
  - An all-zero match emits one beat with out_empty_o=1, out_last_o=1, and pos/idx=0.
  - Handshake rules are the same as for any beat.
- NZ_PAIR_EMPTY_FLAG_EN undefined:
  - An all-zero match is consumed silently and the block stays in IDLE.
  - The out_empty_o port is absent.

## Structure
- Package nz_pkg holds:
  - the state enum (IDLE, RUN);
  - the localparam index width derived from `PREFIX_SUM_SIZE;
  - the beat struct (pos, idx_a, idx_b, last).
- Sub-module lsb_priority_encoder: combinational lowest-set-bit finder over [SIZE:1]. It returns a 1-based position, a one-hot mask, and a single-bit flag.

## Test plan
(All cases use SIZE=8, W=3; bit i is position i.)
- Basic walk: mask_a=8'b1011_0110, mask_b=8'b1110_0100 with correct psums, out_ready_i=1 -> beats (pos,a,b) = (3,1,0), (6,3,1), (8,4,3); last only on the third beat; in_ready_o=1 in that cycle.
- Backpressure: same vector, out_ready_i low for 3 cycles on beat 2 -> (6,3,1) held stable; no beat lost or duplicated.
- Back-to-back: second vector mask_a=mask_b=8'h01 presented during the final beat -> accepted that cycle; next beat (1,0,0,last=1) with no bubble.
- Empty: mask_a=8'h0F, mask_b=8'hF0 -> with NZ_PAIR_EMPTY_FLAG_EN, one beat with empty=1, last=1; without it, no beat and in_ready_o stays 1.
- Full: mask_a=mask_b=8'hFF, psum=1..8 -> 8 beats (i,i-1,i-1); last on pos 8.
- Reset mid-RUN after the first beat of the basic walk -> out_valid_o=0 and in_ready_o=1 while reset is held; after release, no leftover beats.
